// File: rtl/rca_8bit_pkg.sv
// ----------------------------------------------------------------------------
// rca_8bit_pkg
// Shared constants for the 8-bit ripple-carry adder.
//   ADDER_W : datapath width in bits (fixed at 8)
// ----------------------------------------------------------------------------
package rca_8bit_pkg;

    localparam int ADDER_W = 8;

endpackage : rca_8bit_pkg

// File: rtl/rca_8bit_full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// One-bit combinational full adder, the cell of the ripple chain.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit        (a ^ b ^ cin)
//   cout  : carry out      (generate | propagate & cin)
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term is shared between the sum and the carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/rca_8bit.sv
// ----------------------------------------------------------------------------
// rca_8bit
// 8-bit ripple-carry adder with registered outputs. Computes in1 + in2 + cin
// through an explicit chain of full adders and captures the result every
// rising clock edge (one cycle latency, no enable).
// Subtraction: drive in2 = ~b and cin = 1; cout = 1 then means "no borrow".
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears sum/cout
//   in1   : addend A (8 bits)
//   in2   : addend B (8 bits)
//   cin   : carry in to bit 0
//   sum   : registered (in1 + in2 + cin) mod 256
//   cout  : registered carry out of bit 7
// ----------------------------------------------------------------------------
module rca_8bit
    import rca_8bit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDER_W-1:0] in1,
    input  logic [ADDER_W-1:0] in2,
    input  logic               cin,
    output logic [ADDER_W-1:0] sum,
    output logic               cout
);

    // Internal carry vector: c[0] is the carry in, c[ADDER_W] the carry out.
    logic [ADDER_W:0]   c;
    logic [ADDER_W-1:0] sum_d;
    logic               cout_d;
    logic [ADDER_W-1:0] sum_q;
    logic               cout_q;

    assign c[0] = cin;

    for (genvar i = 0; i < ADDER_W; i++) begin : g_ripple
        full_adder u_fa (
            .a    (in1[i]),
            .b    (in2[i]),
            .cin  (c[i]),
            .s    (sum_d[i]),
            .cout (c[i+1])
        );
    end

    assign cout_d = c[ADDER_W];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : rca_8bit

// File: tb/tb_rca_8bit.sv
// ----------------------------------------------------------------------------
// tb_rca_8bit
// Self-checking bench for rca_8bit. Expected results come from a plain
// arithmetic model: {cout, sum} = in1 + in2 + cin as a 9-bit integer.
// Inputs change on the falling clock edge, outputs are sampled 1 time unit
// after the rising edge.
// ----------------------------------------------------------------------------
module tb_rca_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       cin;
    logic [7:0] sum;
    logic       cout;

    int check_cnt = 0;
    int pass_cnt  = 0;

    rca_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: exact 9-bit sum of unsigned operands.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci);
        int unsigned r;
        r = int'(a) + int'(b) + int'(ci);
        return r[8:0];
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got {cout,sum}=0x%03h, expected 0x%03h", tag, got, exp);
        end
    endtask

    // Drive one vector on the falling edge, let it be captured, then check.
    task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [8:0] exp);
        @(negedge clk);
        in1 = a;
        in2 = b;
        cin = ci;
        @(posedge clk);
        #1;
        check(tag, {cout, sum}, exp);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;

        // Reset asserted before any clock edge: outputs must clear at once.
        rst_n = 1'b1;
        in1   = 8'd15;
        in2   = 8'd248;
        cin   = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_async", {cout, sum}, 9'h000);

        // Reset held low across a clock edge: outputs stay cleared.
        @(posedge clk);
        #1;
        check("reset_hold", {cout, sum}, 9'h000);

        // Release on the falling edge; next rising edge captures 15+248+1.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", {cout, sum}, 9'h108);

        // Subtraction sequence (in2 = ~b, cin = 1).
        apply("sub_15_7",  8'd15, ~8'd7,  1'b1, 9'h108);
        apply("sub_6_3",   8'd6,  ~8'd3,  1'b1, 9'h103);
        apply("sub_9_5",   8'd9,  ~8'd5,  1'b1, 9'h104);
        apply("sub_24_11", 8'd24, ~8'd11, 1'b1, 9'h10D);

        // Borrow: 3 - 8 = -5 (251), cout = 0.
        apply("borrow_3_8", 8'd3, ~8'd8, 1'b1, 9'h0FB);

        // Plain add and wrap-around.
        apply("add_200_100",   8'd200, 8'd100, 1'b0, 9'h12C);
        apply("wrap_255_0_1",  8'd255, 8'd0,   1'b1, 9'h100);
        apply("wrap_255_255_1", 8'd255, 8'd255, 1'b1, 9'h1FF);

        // Full carry ripple across all eight stages.
        apply("ripple_cin0", 8'hFF, 8'h00, 1'b0, 9'h0FF);
        apply("ripple_cin1", 8'hFF, 8'h00, 1'b1, 9'h100);

        // Inputs changing between edges must not reach the outputs.
        @(negedge clk);
        in1 = 8'h5A;
        in2 = 8'hA5;
        cin = 1'b0;
        #1;
        check("no_comb_path", {cout, sum}, 9'h100);
        @(posedge clk);
        #1;
        check("capture_after_change", {cout, sum}, 9'h0FF);

        // Mid-stream reset: valid data registered, pulse rst_n between edges.
        apply("pre_midreset", 8'd100, 8'd50, 1'b1, model(8'd100, 8'd50, 1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_clear", {cout, sum}, 9'h000);
        @(negedge clk);
        in1   = 8'd17;
        in2   = 8'd240;
        cin   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_capture", {cout, sum}, model(8'd17, 8'd240, 1'b0));

        // Randomized vectors against the arithmetic model.
        for (int i = 0; i < 200; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            ci = 1'($urandom_range(0, 1));
            apply("random", a, b, ci, model(a, b, ci));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_rca_8bit
